// File: rtl/ex_divider_if.sv
// ============================================================================
// Module   : ex_divider_if
// Brief    : Request/response bundle between execute and the iterative divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ex_divider_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             word;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag_in;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, op, word, a, b, tag_in,
        input  in_ready, busy, out_valid, result, tag_out
    );

    modport slave (
        input  in_valid, op, word, a, b, tag_in,
        output in_ready, busy, out_valid, result, tag_out
    );
endinterface

`default_nettype wire

// File: rtl/ex_divider.sv
// ============================================================================
// Module   : ex_divider
// Brief    : Iterative radix-2 DIV/DIVU/REM/REMU (+W forms) for execute.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_divider #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) (
    input  wire logic    clk,
    input  wire logic    reset,
    input  wire logic    flush,
    ex_divider_if.slave  dif
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic             word_q;
    logic             sa_q;
    logic             sb_q;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] tag_out_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] result_q;

    function automatic logic [WIDTH-1:0] wsext(input logic [WIDTH-1:0] x);
        return {{(WIDTH-32){x[31]}}, x[31:0]};
    endfunction

    // Operand preparation at accept
    logic             signed_d;
    logic [WIDTH-1:0] a_eff_d;
    logic [WIDTH-1:0] b_eff_d;
    logic             sa_d;
    logic             sb_d;
    logic [WIDTH-1:0] mag_a_d;
    logic [WIDTH-1:0] mag_b_d;
    logic [WIDTH-1:0] min_eff_d;
    logic             div0_d;
    logic             ovf_d;
    logic [WIDTH-1:0] spec_raw_d;
    logic [WIDTH-1:0] spec_res_d;

    always_comb begin
        signed_d  = ~dif.op[0];
        a_eff_d   = dif.a;
        b_eff_d   = dif.b;
        min_eff_d = {1'b1, {(WIDTH-1){1'b0}}};
        if (dif.word) begin
            a_eff_d   = signed_d ? wsext(dif.a) : {{(WIDTH-32){1'b0}}, dif.a[31:0]};
            b_eff_d   = signed_d ? wsext(dif.b) : {{(WIDTH-32){1'b0}}, dif.b[31:0]};
            min_eff_d = {{(WIDTH-31){1'b1}}, 31'd0};
        end
        sa_d       = signed_d & a_eff_d[WIDTH-1];
        sb_d       = signed_d & b_eff_d[WIDTH-1];
        mag_a_d    = sa_d ? -a_eff_d : a_eff_d;
        mag_b_d    = sb_d ? -b_eff_d : b_eff_d;
        div0_d     = (b_eff_d == '0);
        ovf_d      = signed_d & (a_eff_d == min_eff_d) & (&b_eff_d);
        spec_raw_d = '0;
        if (div0_d)
            spec_raw_d = dif.op[1] ? a_eff_d : '1;
        else if (ovf_d)
            spec_raw_d = dif.op[1] ? '0 : a_eff_d;
        spec_res_d = dif.word ? wsext(spec_raw_d) : spec_raw_d;
    end

    // One restoring-division step plus the sign fixup of its outcome
    logic [WIDTH:0]   trial_d;
    logic             borrow_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] q_fix_d;
    logic [WIDTH-1:0] r_fix_d;
    logic [WIDTH-1:0] fin_raw_d;
    logic [WIDTH-1:0] fin_d;

    always_comb begin
        trial_d   = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};
        borrow_d  = trial_d[WIDTH];
        rem_d     = borrow_d ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial_d[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], ~borrow_d};
        q_fix_d   = (sa_q ^ sb_q) ? -quo_d : quo_d;
        r_fix_d   = sa_q ? -rem_d : rem_d;
        fin_raw_d = op_q[1] ? r_fix_d : q_fix_d;
        fin_d     = word_q ? wsext(fin_raw_d) : fin_raw_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            word_q    <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            tag_q     <= '0;
            tag_out_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dif.in_valid) begin
                        op_q   <= dif.op;
                        word_q <= dif.word;
                        sa_q   <= sa_d;
                        sb_q   <= sb_d;
                        tag_q  <= dif.tag_in;
                        rem_q  <= '0;
                        // W dividends sit in the top half so 32 shifts drain them
                        quo_q  <= dif.word ? {mag_a_d[31:0], {(WIDTH-32){1'b0}}} : mag_a_d;
                        div_q  <= mag_b_d;
                        cnt_q  <= dif.word ? CNT_W'(31) : CNT_W'(WIDTH - 1);
                        if (div0_d || ovf_d) begin
                            result_q  <= spec_res_d;
                            tag_out_q <= dif.tag_in;
                            state_q   <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        result_q  <= fin_d;
                        tag_out_q <= tag_q;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dif.in_ready  = (state_q == IDLE);
    assign dif.busy      = (state_q != IDLE);
    assign dif.out_valid = (state_q == DONE);
    assign dif.result    = result_q;
    assign dif.tag_out   = tag_out_q;

endmodule

`default_nettype wire

// File: doc/ex_divider.md
# ex_divider

Iterative radix-2 integer divider for the execute stage of the RISC-V pipeline. It implements DIV, DIVU, REM, REMU and their 32-bit W forms. It is a multi-cycle unit: it accepts one operation when idle, holds the pipeline through `busy`, and returns a result and destination tag that execute places into its output to the memory stage. Special cases (divide-by-zero, signed overflow) finish in one cycle.

## Interface
- `WIDTH`, default 64: datapath width in bits (XLEN).
- `TAG_W`, default 5: width of the destination-register tag carried through the divider.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `flush` in 1: kill the operation in flight (branch mispredict or trap).
- `in_valid` in 1: request to start a divide.
- `in_ready` out 1: divider is idle and can accept. Equals state==IDLE.
- `op` in 2: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
- `word` in 1: W variant. Use low 32 bits of the operands; result is sign-extended from bit 31.
- `a` in WIDTH: dividend.
- `b` in WIDTH: divisor.
- `tag_in` in TAG_W: destination register address.
- `busy` out 1: high in CALC and DONE; execute stalls while it is high.
- `out_valid` out 1: result valid, one-cycle pulse.
- `result` out WIDTH: quotient or remainder.
- `tag_out` out TAG_W: tag latched at accept.

## Operation
- States: IDLE, CALC, DONE.
- Accept: `in_valid & in_ready & !flush` at a clock edge. At accept the divider latches `op`, `word`, `tag_in`, the operand signs, and the absolute values of the operands.
  - Signed ops (DIV, REM) use two's-complement magnitude. Unsigned ops use the raw value.
  - When `word`=1, operands are first reduced to 32 bits and then sign- or zero-extended per op.
- Transitions:
  - IDLE→DONE on accept of a special case.
  - IDLE→CALC on any other accept.
- CALC runs N=WIDTH iterations (N=32 when `word`). Each iteration:
  - shift {rem,quo} left by 1;
  - trial-subtract the divisor magnitude from rem;
  - on no borrow, keep the difference and set quo[0]=1.
- A down-counter tracks the iterations. CALC→DONE on the cycle the counter reaches 0.
- Fixup on CALC→DONE, registered into `result`:
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - W forms: result[WIDTH-1:32] = result[31], including DIVUW and REMUW.
- Special cases, decided at accept and checked on the effective (possibly 32-bit) operands:
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative value, divisor = −1): quotient = dividend; remainder = 0.
- DONE: `out_valid`=1 for exactly one cycle, then →IDLE. Execute does not back-pressure the result.
- `in_valid` while not in IDLE is ignored and no request is queued.
- `flush` in any state forces →IDLE at the next edge; `out_valid` is not asserted for the killed operation.
- `flush` and `in_valid` in the same IDLE cycle: flush wins and nothing is accepted.
- `reset` has priority over `flush` and accept.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `busy`=0, `out_valid`=0, `result`=0, `tag_out`=0, counter=0.
- Latency counts accept edge = cycle 0:
  - normal 64-bit op: CALC in cycles 1..64, `out_valid` in cycle 65;
  - W op: `out_valid` in cycle 33;
  - special case: `out_valid` in cycle 1.
- `result` and `tag_out` are stable from DONE until the next DONE. They are only meaningful while `out_valid`=1.
- Back-to-back operation: a new accept is possible in the cycle after DONE (state IDLE). Minimum issue interval is 66 cycles for 64-bit ops and 2 cycles for special cases.
- Reset asserted mid-CALC: the next edge goes to IDLE with all outputs at their reset values. No `out_valid` is produced for the aborted operation.
- All outputs are driven from registers or from the state only. There is no combinational path from `in_valid` or the operands to any output.

## Test plan
- DIVU a=100, b=7 → `out_valid` in cycle 65 with `result`=14; REMU with the same operands → 2; `tag_out` equals the accepted tag.
- DIV a=−100, b=7 → −14 (0xFFFF_FFFF_FFFF_FFF2); REM a=−100, b=7 → −2; REM a=100, b=−7 → 2.
- Divide by zero: DIVU a=5, b=0 → 0xFFFF_FFFF_FFFF_FFFF; REM a=5, b=0 → 5; both in cycle 1.
- Overflow: DIV a=0x8000_0000_0000_0000, b=−1 → a, in cycle 1; REM → 0. DIVW a=0x8000_0000, b=−1 → 0xFFFF_FFFF_8000_0000.
- DIVUW a=0x1_FFFF_FFFE, b=1 → 0xFFFF_FFFF_FFFF_FFFE in cycle 33 (upper bits ignored, result sign-extended).
- Flush in cycle 20 of a CALC → IDLE at cycle 21 with no `out_valid`. A new DIVU 9/3 accepted in cycle 21 → 3 in cycle 86. `in_valid` pulses during CALC are ignored. Reset in cycle 30 → all outputs at reset values in cycle 31.
